out_port_uart_tx: RTL and testbench
===================================

// Module: out_port_uart_tx
// PURPOSE
//  Downstream consumer of the processor's 8-bit OUT port. It buffers each byte the core
//  emits with its OUT instruction in a small FIFO, then serialises the bytes onto a UART
//  line: 8N1, LSB first. The core therefore never stalls on a slow serial link; bytes are
//  dropped only on FIFO overflow, which is flagged.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per UART bit (>=2); 868 = 115200 baud @ 100 MHz
//  FIFO_DEPTH    4    byte FIFO entries; power of two, >=2
// PORTS
//  clock     in   1  system clock; all logic on posedge clock
//  reset     in   1  synchronous, active-high reset
//  wr_en     in   1  one-cycle strobe: OUT instruction executed, wr_data valid
//  wr_data   in   8  byte from processor OUT register
//  full      out  1  FIFO holds FIFO_DEPTH bytes (registered)
//  busy      out  1  FIFO non-empty or frame in progress
//  overflow  out  1  sticky: a write was dropped because FIFO was full
//  tx        out  1  UART serial output, idle high
// BEHAVIOUR
//  Reset (sampled on posedge, wins over everything):
//   - tx=1, full=0, busy=0, overflow=0; FIFO pointers/count cleared; FSM->IDLE.
//   - wr_en in a reset cycle is ignored.
//   - Reset mid-frame aborts the frame; tx is high from the next edge.
//  FIFO:
//   - Write accepted on an edge with wr_en=1 and full=0 (full = pre-edge state).
//   - wr_en while full: byte dropped, overflow<=1 until reset. This holds even if a
//     pop occurs on the same edge.
//   - Simultaneous accepted write and pop: count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, STOP; bit timer counts 0..CLKS_PER_BIT-1.
//   - IDLE:  if FIFO non-empty, pop head into shift reg -> START, timer=0. tx=1.
//   - START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//   - DATA:  tx=shift[0]. Each CLKS_PER_BIT cycles, shift right and bit_idx+1.
//            After bit 7 -> STOP.
//   - STOP:  tx=1 for CLKS_PER_BIT cycles. On the last stop cycle:
//            - if FIFO non-empty, pop and go directly to START (no idle gap);
//            - else go to IDLE.
//  Frame = 10*CLKS_PER_BIT cycles.
//  Latency: write accepted on edge N with FSM idle and FIFO empty -> pop on edge N+1,
//   tx falls on edge N+2.
//  tx is registered (glitch-free).
//  busy = (state!=IDLE) | (count!=0), registered.
//  busy falls at the edge where STOP exits to IDLE with FIFO empty.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Single 0xA5 write while idle -> tx low at N+2 for 4 cycles, then data bits
//    1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; busy 1 from N+1 until frame end.
//  2 wr_en on 6 consecutive cycles (0x01..0x06) from idle -> 0x01..0x05 transmitted in
//    order; 0x06 dropped; full=1 after 5th write; overflow=1 and stays 1.
//  3 Writes 0x00 then 0xFF -> 80 contiguous cycles: start, 8 zeros, stop, start, 8 ones,
//    stop; no idle cycle between frames.
//  4 Reset asserted 10 cycles into a frame with 2 bytes queued -> next edge tx=1, busy=0,
//    full=0, overflow=0; no further frames.
//  5 wr_en=1 with reset=1 -> nothing stored; tx stays 1, busy stays 0.
//  6 Write while full on the same edge as a STOP->START pop -> byte dropped, overflow=1,
//    count goes DEPTH-1.

Source files
------------

// File: rtl/out_port_uart_tx_if.sv
// Bus between the processor's OUT port and the UART transmitter.
// Ports:
//   wr_en    - one-cycle strobe, wr_data valid (processor -> transmitter)
//   wr_data  - byte from the OUT register (processor -> transmitter)
//   full     - byte FIFO holds FIFO_DEPTH bytes (transmitter -> processor)
//   busy     - FIFO non-empty or frame in progress (transmitter -> processor)
//   overflow - sticky dropped-write flag (transmitter -> processor)
//   tx       - UART serial line, idle high
interface out_port_uart_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       overflow;
  logic       tx;

  modport master (
    output wr_en, wr_data,
    input  full, busy, overflow, tx
  );

  modport slave (
    input  wr_en, wr_data,
    output full, busy, overflow, tx
  );
endinterface

// File: rtl/out_port_uart_tx.sv
// Buffers bytes written by the processor's OUT instruction in a small FIFO and
// serialises them onto a UART line (8N1, LSB first). Writes arriving while the
// FIFO is full are dropped and latched into a sticky overflow flag.
// Ports:
//   clock - system clock, all logic on its rising edge
//   reset - synchronous, active-high; aborts any frame in progress
//   bus   - slave side of out_port_uart_tx_if (wr_en/wr_data in;
//           full/busy/overflow/tx out, all registered)
module out_port_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clock,
  input  logic               reset,
  out_port_uart_tx_if.slave  bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic          tx_level;
  logic          tx_r;
  logic          busy_r;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_next;
  logic          full_r;
  logic          overflow_r;
  logic          push, pop;
  logic          timer_done;

  // full_r is the pre-edge full state, so a write on the same edge as a pop
  // from a full FIFO is still dropped.
  assign push       = bus.wr_en & ~full_r;
  assign timer_done = (timer == TIMER_MAX);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      full_r <= (count_next == DEPTH_C);
      if (bus.wr_en && full_r) overflow_r <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= bus.wr_data;
  end

  // Next-state logic. The last stop-bit cycle pops straight into START so
  // back-to-back bytes leave no idle gap on the line.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    pop          = 1'b0;
    tx_level     = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          timer_next = '0;
          state_next = START;
        end
      end
      START: begin
        tx_level = 1'b0;
        if (timer_done) begin
          timer_next   = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      DATA: begin
        tx_level = shift[0];
        if (timer_done) begin
          timer_next   = '0;
          shift_next   = shift >> 1;
          bit_idx_next = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      STOP: begin
        tx_level = 1'b1;
        if (timer_done) begin
          timer_next = '0;
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is the registered line level of the current state, hence one cycle
  // behind the state. busy uses the next state so it drops on the very edge
  // the transmitter returns to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      tx_r    <= tx_level;
      busy_r  <= (state_next != IDLE) | (count != '0);
    end
  end

  assign bus.full     = full_r;
  assign bus.busy     = busy_r;
  assign bus.overflow = overflow_r;
  assign bus.tx       = tx_r;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Self-checking bench for out_port_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A queue-based reference model tracks FIFO contents and frame position and
// predicts tx/busy/full/overflow after every clock edge.
module tb_out_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  out_port_uart_tx_if bus ();

  out_port_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: queued bytes, byte on the line, cycles of the
  // current frame still to go (0 = idle), and predicted outputs.
  logic [7:0] mq[$];
  logic [7:0] cur_byte  = 8'h00;
  int         frame_left = 0;
  logic       m_tx = 1'b1, m_busy = 1'b0, m_full = 1'b0, m_ovf = 1'b0;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic w, input logic [7:0] d);
    int pre_size;
    int pos;
    int b;
    if (r) begin
      mq.delete();
      frame_left = 0;
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      pre_size = mq.size();
      if (frame_left == 0) begin
        m_tx = 1'b1;
      end else begin
        pos = FRAME - frame_left;
        b   = pos / CPB;
        if (b == 0)      m_tx = 1'b0;
        else if (b == 9) m_tx = 1'b1;
        else             m_tx = cur_byte[b-1];
      end
      if (frame_left > 1) begin
        frame_left--;
      end else if (pre_size != 0) begin
        cur_byte   = mq.pop_front();
        frame_left = FRAME;
      end else begin
        frame_left = 0;
      end
      if (w) begin
        if (pre_size == DEPTH) m_ovf = 1'b1;
        else                   mq.push_back(d);
      end
      m_full = (mq.size() == DEPTH);
      m_busy = (frame_left != 0) || (pre_size != 0);
    end
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, " tx"},       bus.tx,       m_tx);
    check1({tag, " busy"},     bus.busy,     m_busy);
    check1({tag, " full"},     bus.full,     m_full);
    check1({tag, " overflow"}, bus.overflow, m_ovf);
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] d,
                               input string tag);
    reset       = r;
    bus.wr_en   = w;
    bus.wr_data = d;
    @(posedge clock);
    modelStep(r, w, d);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, tag);
  endtask

  task automatic waitIdle(input int bound, input string tag);
    int k = 0;
    while (bus.busy && k < bound) begin
      applyStimulus(1'b0, 1'b0, 8'h00, tag);
      k++;
    end
    check1({tag, " drained"}, bus.busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [79:0] got;
    logic [79:0] expv;
    int k;

    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // Reset with wr_en high, then a single 0xA5 frame (bits 1,0,1,0,0,1,0,1).
    vecs[0]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, "vec model");
      check1($sformatf("vec%0d tx", i),       bus.tx,       vecs[i].tx);
      check1($sformatf("vec%0d busy", i),     bus.busy,     vecs[i].busy);
      check1($sformatf("vec%0d full", i),     bus.full,     vecs[i].full);
      check1($sformatf("vec%0d overflow", i), bus.overflow, vecs[i].ovf);
    end
    idleCycles(45, "t1 tail");
    check1("t1 idle tx", bus.tx, 1'b1);
    check1("t1 idle busy", bus.busy, 1'b0);

    // Six back-to-back writes: the sixth is dropped.
    applyStimulus(1'b1, 1'b0, 8'h00, "t2 reset");
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i), "t2 write");
      if (i == 5) check1("t2 full after 5th", bus.full, 1'b1);
      if (i == 6) check1("t2 overflow set", bus.overflow, 1'b1);
    end
    waitIdle(400, "t2");
    check1("t2 overflow sticky", bus.overflow, 1'b1);

    // 0x00 then 0xFF: two frames with no idle gap.
    applyStimulus(1'b1, 1'b0, 8'h00, "t3 reset");
    applyStimulus(1'b0, 1'b1, 8'h00, "t3 write0");
    applyStimulus(1'b0, 1'b1, 8'hFF, "t3 write1");
    k = 0;
    while (bus.tx !== 1'b0 && k < 10) begin
      applyStimulus(1'b0, 1'b0, 8'h00, "t3 wait");
      k++;
    end
    check1("t3 start bit seen", bus.tx, 1'b0);
    got[0] = bus.tx;
    for (int i = 1; i < 80; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, "t3 frames");
      got[i] = bus.tx;
    end
    for (int i = 0; i < 80; i++) begin
      if ((i % 40) / 4 == 0)      expv[i] = 1'b0;
      else if ((i % 40) / 4 == 9) expv[i] = 1'b1;
      else                        expv[i] = (i / 40 == 1);
    end
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL t3 waveform: got %h expected %h", got, expv);
    end
    waitIdle(20, "t3");

    // Reset mid-frame with bytes still queued.
    applyStimulus(1'b1, 1'b0, 8'h00, "t4 reset");
    applyStimulus(1'b0, 1'b1, 8'h00, "t4 write");
    applyStimulus(1'b0, 1'b1, 8'h3C, "t4 write");
    applyStimulus(1'b0, 1'b1, 8'hC3, "t4 write");
    idleCycles(9, "t4 into frame");
    check1("t4 line low before reset", bus.tx, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, "t4 abort");
    check1("t4 abort tx", bus.tx, 1'b1);
    check1("t4 abort busy", bus.busy, 1'b0);
    check1("t4 abort full", bus.full, 1'b0);
    check1("t4 abort overflow", bus.overflow, 1'b0);
    idleCycles(100, "t4 quiet");
    check1("t4 still idle", bus.busy, 1'b0);

    // Write while full on the same edge as the STOP->START pop.
    applyStimulus(1'b1, 1'b0, 8'h00, "t6 reset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h11 + 8'(i), "t6 fill");
    check1("t6 full before collide", bus.full, 1'b1);
    k = 0;
    while (frame_left != 1 && k < 200) begin
      applyStimulus(1'b0, 1'b0, 8'h00, "t6 wait stop");
      k++;
    end
    checks++;
    if (frame_left != 1) begin
      failures++;
      $display("[TB] FAIL t6 stop edge: got frame_left=%0d required 1", frame_left);
    end
    applyStimulus(1'b0, 1'b1, 8'hEE, "t6 collide");
    check1("t6 overflow", bus.overflow, 1'b1);
    check1("t6 full cleared", bus.full, 1'b0);
    waitIdle(400, "t6");

    // Randomized traffic with sparse and bursty phases and rare resets.
    applyStimulus(1'b1, 1'b0, 8'h00, "rand reset");
    for (int i = 0; i < 4000; i++) begin
      logic r;
      logic w;
      r = ($urandom_range(0, 399) == 0);
      if (((i / 500) % 2) == 1) w = ($urandom_range(0, 3) == 0);
      else                      w = ($urandom_range(0, 60) == 0);
      applyStimulus(r, w, 8'($urandom), "rand");
    end
    waitIdle(600, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
